// File: rtl/rob_commit_if.sv
// Dispatch / completion / retirement bundle for the reorder buffer.
// master: the surrounding pipeline (rename, execute, retire consumer).
// slave: the ROB itself.
// Optional macro ROB_FLUSH_EN adds the flush request.
interface rob_commit_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned AREG_W = 5,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned PC_W   = 12
) ();

`ifdef ROB_FLUSH_EN
  logic              flush;
`endif

  // Allocation from rename/dispatch
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dest;
  logic [AREG_W-1:0] alloc_areg;
  logic [PREG_W-1:0] alloc_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [PC_W-1:0]   alloc_pc;
  logic [TAG_W-1:0]  alloc_tag;

  // Completion ports from execute
  logic              cmp0_valid;
  logic [TAG_W-1:0]  cmp0_tag;
  logic              cmp1_valid;
  logic [TAG_W-1:0]  cmp1_tag;

  // In-order retirement
  logic              commit_ready;
  logic              commit_valid;
  logic              commit_has_dest;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_preg;
  logic [PREG_W-1:0] commit_old_preg;
  logic [PC_W-1:0]   commit_pc;

  logic [TAG_W:0]    count;

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output alloc_valid, alloc_has_dest, alloc_areg, alloc_preg, alloc_old_preg, alloc_pc,
    input  alloc_ready, alloc_tag,
    output cmp0_valid, cmp0_tag, cmp1_valid, cmp1_tag,
    output commit_ready,
    input  commit_valid, commit_has_dest, commit_areg, commit_preg, commit_old_preg,
    input  commit_pc, count
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  alloc_valid, alloc_has_dest, alloc_areg, alloc_preg, alloc_old_preg, alloc_pc,
    output alloc_ready, alloc_tag,
    input  cmp0_valid, cmp0_tag, cmp1_valid, cmp1_tag,
    input  commit_ready,
    output commit_valid, commit_has_dest, commit_areg, commit_preg, commit_old_preg,
    output commit_pc, count
  );

endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate at tail, out-of-order completion on two
// ports, in-order retirement at head feeding architectural state and the
// physical-register free list.
// Optional macro ROB_FLUSH_EN: adds a synchronous flush that empties the ROB.
module rob_commit #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned AREG_W = 5,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned PC_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  rob_commit_if.slave io_rob
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]    r_head;
  logic [TAG_W:0]    r_tail;
  logic [TAG_W:0]    r_count;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_dest;
  logic [AREG_W-1:0] r_areg     [DEPTH];
  logic [PREG_W-1:0] r_preg     [DEPTH];
  logic [PREG_W-1:0] r_old_preg [DEPTH];
  logic [PC_W-1:0]   r_pc       [DEPTH];

  logic [TAG_W-1:0]  w_head_idx;
  logic [TAG_W-1:0]  w_tail_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_flush;
  logic              w_alloc_ready;
  logic              w_alloc_fire;
  logic              w_commit_valid;
  logic              w_retire;

`ifdef ROB_FLUSH_EN
  assign w_flush = io_rob.flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_head_idx = r_head[TAG_W-1:0];
  assign w_tail_idx = r_tail[TAG_W-1:0];
  assign w_empty    = (r_head == r_tail);
  // Readiness comes from registered occupancy only: a retire in the same
  // cycle does not free a slot for allocation until the next cycle.
  assign w_full     = (r_count == FULL_CNT);

  assign w_alloc_ready  = !w_full && !w_flush;
  assign w_alloc_fire   = io_rob.alloc_valid && w_alloc_ready;
  assign w_commit_valid = !w_empty && r_done[w_head_idx] && !w_flush;
  assign w_retire       = w_commit_valid && io_rob.commit_ready;

  assign io_rob.alloc_ready  = w_alloc_ready;
  assign io_rob.alloc_tag    = w_tail_idx;
  assign io_rob.commit_valid = w_commit_valid;
  assign io_rob.count        = r_count;

  // Head entry presented to the retire consumer, zeroed when not retirable.
  always_comb begin
    io_rob.commit_has_dest = 1'b0;
    io_rob.commit_areg     = '0;
    io_rob.commit_preg     = '0;
    io_rob.commit_old_preg = '0;
    io_rob.commit_pc       = '0;
    if (w_commit_valid) begin
      io_rob.commit_has_dest = r_has_dest[w_head_idx];
      io_rob.commit_areg     = r_areg[w_head_idx];
      io_rob.commit_preg     = r_preg[w_head_idx];
      io_rob.commit_old_preg = r_old_preg[w_head_idx];
      io_rob.commit_pc       = r_pc[w_head_idx];
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_head <= r_head + 1'b1;
      end
      unique case ({w_alloc_fire, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-entry valid/done flags. Later assignments take priority: retire
  // clears the head, and allocation overrides any stray completion of the
  // tail slot so a fresh entry always starts not-done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (io_rob.cmp0_valid && r_valid[io_rob.cmp0_tag]) begin
        r_done[io_rob.cmp0_tag] <= 1'b1;
      end
      if (io_rob.cmp1_valid && r_valid[io_rob.cmp1_tag]) begin
        r_done[io_rob.cmp1_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
      end
    end
  end

  // Entry payload; only observed through valid entries, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_has_dest[w_tail_idx] <= io_rob.alloc_has_dest;
      r_areg[w_tail_idx]     <= io_rob.alloc_areg;
      r_preg[w_tail_idx]     <= io_rob.alloc_preg;
      r_old_preg[w_tail_idx] <= io_rob.alloc_old_preg;
      r_pc[w_tail_idx]       <= io_rob.alloc_pc;
    end
  end

  // Occupancy stays within the ring and agrees with the pointer distance.
  a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= FULL_CNT);
  a_count_ptrs  : assert property (@(posedge clk) disable iff (rst)
                                   r_count == (r_tail - r_head));

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset, out-of-order completion with in-order
// retire, dual completion, back-pressure, full boundary and wrap, async reset
// mid-operation, and flush when ROB_FLUSH_EN is defined.
module tb_rob_commit;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned AREG_W = 5;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned PC_W   = 12;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  rob_commit_if #(
    .TAG_W (TAG_W),
    .AREG_W(AREG_W),
    .PREG_W(PREG_W),
    .PC_W  (PC_W)
  ) u_if ();

  rob_commit #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .AREG_W(AREG_W),
    .PREG_W(PREG_W),
    .PC_W  (PC_W)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_rob(u_if.slave)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
`ifdef ROB_FLUSH_EN
    u_if.flush = 1'b0;
`endif
    u_if.alloc_valid    = 1'b0;
    u_if.alloc_has_dest = 1'b0;
    u_if.alloc_areg     = '0;
    u_if.alloc_preg     = '0;
    u_if.alloc_old_preg = '0;
    u_if.alloc_pc       = '0;
    u_if.cmp0_valid     = 1'b0;
    u_if.cmp0_tag       = '0;
    u_if.cmp1_valid     = 1'b0;
    u_if.cmp1_tag       = '0;
    u_if.commit_ready   = 1'b0;
  endtask

  task automatic alloc(input int unsigned exp_tag, input int unsigned hd,
                       input int unsigned areg, input int unsigned preg,
                       input int unsigned old, input int unsigned pc);
    u_if.alloc_valid    = 1'b1;
    u_if.alloc_has_dest = hd[0];
    u_if.alloc_areg     = AREG_W'(areg);
    u_if.alloc_preg     = PREG_W'(preg);
    u_if.alloc_old_preg = PREG_W'(old);
    u_if.alloc_pc       = PC_W'(pc);
    check_eq("alloc_ready", 32'(u_if.alloc_ready), 1);
    check_eq("alloc_tag", 32'(u_if.alloc_tag), exp_tag);
    step();
    u_if.alloc_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_count"}, 32'(u_if.count), 0);
    check_eq({tag, "_alloc_ready"}, 32'(u_if.alloc_ready), 1);
    check_eq({tag, "_commit_valid"}, 32'(u_if.commit_valid), 0);
    check_eq({tag, "_alloc_tag"}, 32'(u_if.alloc_tag), 0);
    check_eq({tag, "_commit_pc"}, 32'(u_if.commit_pc), 0);
    check_eq({tag, "_commit_old_preg"}, 32'(u_if.commit_old_preg), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    step();

    // Out-of-order completion, in-order retirement.
    alloc(0, 1, 1, 10, 20, 12'h100);
    alloc(1, 0, 2, 11, 21, 12'h104);
    alloc(2, 1, 3, 12, 22, 12'h108);
    check_eq("oo_count3", 32'(u_if.count), 3);
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd2;
    step();
    check_eq("oo_after_c2", 32'(u_if.commit_valid), 0);
    u_if.cmp0_tag = 4'd1;
    step();
    check_eq("oo_after_c1", 32'(u_if.commit_valid), 0);
    u_if.cmp0_tag = 4'd0;
    step();
    u_if.cmp0_valid = 1'b0;
    check_eq("oo_t0_valid", 32'(u_if.commit_valid), 1);
    check_eq("oo_t0_pc", 32'(u_if.commit_pc), 12'h100);
    check_eq("oo_t0_preg", 32'(u_if.commit_preg), 10);
    check_eq("oo_t0_old", 32'(u_if.commit_old_preg), 20);
    check_eq("oo_t0_areg", 32'(u_if.commit_areg), 1);
    check_eq("oo_t0_hd", 32'(u_if.commit_has_dest), 1);
    u_if.commit_ready = 1'b1;
    step();
    check_eq("oo_t1_valid", 32'(u_if.commit_valid), 1);
    check_eq("oo_t1_pc", 32'(u_if.commit_pc), 12'h104);
    check_eq("oo_t1_hd", 32'(u_if.commit_has_dest), 0);
    check_eq("oo_t1_preg", 32'(u_if.commit_preg), 11);
    check_eq("oo_t1_old", 32'(u_if.commit_old_preg), 21);
    check_eq("oo_t1_count", 32'(u_if.count), 2);
    step();
    check_eq("oo_t2_valid", 32'(u_if.commit_valid), 1);
    check_eq("oo_t2_pc", 32'(u_if.commit_pc), 12'h108);
    check_eq("oo_t2_old", 32'(u_if.commit_old_preg), 22);
    check_eq("oo_t2_count", 32'(u_if.count), 1);
    step();
    check_eq("oo_done_valid", 32'(u_if.commit_valid), 0);
    check_eq("oo_done_count", 32'(u_if.count), 0);
    check_eq("oo_done_pc_zero", 32'(u_if.commit_pc), 0);
    u_if.commit_ready = 1'b0;

    // Dual completion of tag 3, completion of unallocated tag 9, back-pressure.
    alloc(3, 1, 3, 19, 43, 12'h203);
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd3;
    u_if.cmp1_valid = 1'b1;
    u_if.cmp1_tag   = 4'd3;
    step();
    u_if.cmp0_valid = 1'b0;
    u_if.cmp1_tag   = 4'd9;
    check_eq("dual_valid", 32'(u_if.commit_valid), 1);
    check_eq("dual_pc", 32'(u_if.commit_pc), 12'h203);
    step();
    u_if.cmp1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_valid", 32'(u_if.commit_valid), 1);
      check_eq("bp_pc", 32'(u_if.commit_pc), 12'h203);
      check_eq("bp_preg", 32'(u_if.commit_preg), 19);
      check_eq("bp_old", 32'(u_if.commit_old_preg), 43);
      check_eq("bp_count", 32'(u_if.count), 1);
    end
    u_if.commit_ready = 1'b1;
    step();
    u_if.commit_ready = 1'b0;
    check_eq("bp_retire_count", 32'(u_if.count), 0);
    check_eq("bp_retire_valid", 32'(u_if.commit_valid), 0);
    step();
    check_eq("bp_single_count", 32'(u_if.count), 0);

    // Tags 4..9; entry 9 must not have picked up the earlier stray completion.
    for (int k = 4; k <= 9; k++) begin
      alloc(k, 1, k, k + 16, k + 40, 12'h200 + k);
    end
    check_eq("t49_count", 32'(u_if.count), 6);
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd4;
    u_if.cmp1_valid = 1'b1;
    u_if.cmp1_tag   = 4'd5;
    step();
    u_if.cmp0_tag = 4'd6;
    u_if.cmp1_tag = 4'd7;
    step();
    u_if.cmp0_tag   = 4'd8;
    u_if.cmp1_valid = 1'b0;
    step();
    u_if.cmp0_valid   = 1'b0;
    u_if.commit_ready = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      check_eq("t48_valid", 32'(u_if.commit_valid), 1);
      check_eq("t48_pc", 32'(u_if.commit_pc), 12'h200 + k);
      check_eq("t48_preg", 32'(u_if.commit_preg), k + 16);
      step();
    end
    check_eq("t9_not_done", 32'(u_if.commit_valid), 0);
    check_eq("t9_count", 32'(u_if.count), 1);
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd9;
    step();
    u_if.cmp0_valid = 1'b0;
    check_eq("t9_valid", 32'(u_if.commit_valid), 1);
    check_eq("t9_pc", 32'(u_if.commit_pc), 12'h209);
    step();
    u_if.commit_ready = 1'b0;
    check_eq("t9_retired", 32'(u_if.count), 0);

    // Asynchronous reset between edges with five entries in flight.
    for (int k = 10; k <= 14; k++) begin
      alloc(k, 1, k, k, k, 12'h400 + k);
    end
    check_eq("mid_count5", 32'(u_if.count), 5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step();

    // Full boundary, refused allocation, wrap of the tail to 0.
    for (int k = 0; k < 16; k++) begin
      alloc(k, 1, k, k, 63 - k, 12'h300 + k);
    end
    check_eq("full_count", 32'(u_if.count), 16);
    check_eq("full_ready", 32'(u_if.alloc_ready), 0);
    check_eq("full_cvalid", 32'(u_if.commit_valid), 0);
    u_if.alloc_valid = 1'b1;
    u_if.alloc_pc    = 12'hfff;
    step();
    check_eq("full_17th_count", 32'(u_if.count), 16);
    check_eq("full_17th_ready", 32'(u_if.alloc_ready), 0);
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd0;
    step();
    u_if.cmp0_valid = 1'b0;
    check_eq("full_c0_valid", 32'(u_if.commit_valid), 1);
    check_eq("full_c0_pc", 32'(u_if.commit_pc), 12'h300);
    check_eq("full_c0_old", 32'(u_if.commit_old_preg), 63);
    u_if.commit_ready = 1'b1;
    step();
    u_if.commit_ready = 1'b0;
    check_eq("full_retire_count", 32'(u_if.count), 15);
    check_eq("full_retire_ready", 32'(u_if.alloc_ready), 1);
    check_eq("full_wrap_tag", 32'(u_if.alloc_tag), 0);
    step();
    u_if.alloc_valid = 1'b0;
    check_eq("full_realloc_count", 32'(u_if.count), 16);
    check_eq("full_realloc_ready", 32'(u_if.alloc_ready), 0);
    check_eq("full_realloc_cvalid", 32'(u_if.commit_valid), 0);

`ifdef ROB_FLUSH_EN
    // Flush with six entries, three done, and a concurrent allocation request.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      alloc(k, 1, k, k, k, 12'h500 + k);
    end
    u_if.cmp0_valid = 1'b1;
    u_if.cmp0_tag   = 4'd0;
    u_if.cmp1_valid = 1'b1;
    u_if.cmp1_tag   = 4'd1;
    step();
    u_if.cmp0_tag   = 4'd2;
    u_if.cmp1_valid = 1'b0;
    step();
    u_if.cmp0_valid = 1'b0;
    check_eq("fl_pre_cvalid", 32'(u_if.commit_valid), 1);
    u_if.flush        = 1'b1;
    u_if.alloc_valid  = 1'b1;
    u_if.commit_ready = 1'b1;
    #1;
    check_eq("fl_ready_gated", 32'(u_if.alloc_ready), 0);
    check_eq("fl_cvalid_gated", 32'(u_if.commit_valid), 0);
    step();
    u_if.flush        = 1'b0;
    u_if.alloc_valid  = 1'b0;
    u_if.commit_ready = 1'b0;
    check_eq("fl_count", 32'(u_if.count), 0);
    check_eq("fl_cvalid", 32'(u_if.commit_valid), 0);
    check_eq("fl_tag", 32'(u_if.alloc_tag), 0);
    check_eq("fl_ready", 32'(u_if.alloc_ready), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
